strobe_sequencer: RTL and testbench

//  Acquisition timing controller driven by the SPI-programmed FPGA parameter registers.

---
 rtl/strobe_sequencer.sv | 160 ++++++++++++++++
 tb/tb_strobe_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_sequencer.sv
// Acquisition timing controller: sequences back-to-back detector integrations, a single lamp
// strobe inside each integration, and a free-running continuous-strobe square wave.
module strobe_sequencer #(
  parameter int MS_DIV = 48000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        acq_enable,
  input  logic [15:0] cfg_countbase,
  input  logic [15:0] cfg_strbcount,
  input  logic [15:0] cfg_intclock,
  input  logic [15:0] cfg_sslowdelay,
  input  logic [15:0] cfg_sshighdelay,
  input  logic [15:0] cfg_lampenable,
  output logic        int_start,
  output logic        int_done,
  output logic        int_active,
  output logic [15:0] int_count,
  output logic        ss_out,
  output logic        cs_out
);

  localparam int SW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(MS_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] sub_reg, sub_next;
  logic [15:0]   ms_reg, ms_next;
  logic [15:0]   lint_reg, lint_next;
  logic [15:0]   hi_reg, hi_next;
  logic [15:0]   lo_reg, lo_next;
  logic [15:0]   cb_reg, cb_next;
  logic [15:0]   sc_reg, sc_next;
  logic [15:0]   pre_reg, pre_next;
  logic [15:0]   strb_reg, strb_next;
  logic          lampen_reg, lampen_next;
  logic          cs_next;
  logic [15:0]   count_next;
  logic          int_last;
  logic          start_int;

  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // The integration position is kept as (ms, sub-ms) so the strobe window compares in ms units.
  assign int_last  = (state_reg == RUN) && (sub_reg == SUB_LAST) && (ms_reg == lint_reg - 16'd1);
  assign start_int = acq_enable && ((state_reg == IDLE) || int_last);

  always_comb begin
    state_next  = state_reg;
    sub_next    = sub_reg;
    ms_next     = ms_reg;
    lint_next   = lint_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    cb_next     = cb_reg;
    sc_next     = sc_reg;
    pre_next    = pre_reg;
    strb_next   = strb_reg;
    lampen_next = lampen_reg;
    cs_next     = cs_out;
    count_next  = int_count;

    if (state_reg == IDLE) begin
      if (acq_enable) begin
        state_next  = RUN;
        cb_next     = at_least_one(cfg_countbase);
        sc_next     = at_least_one(cfg_strbcount);
        lampen_next = cfg_lampenable[0];
        pre_next    = 16'd0;
        strb_next   = 16'd0;
        cs_next     = 1'b0;
        count_next  = 16'd0;
      end
    end else begin
      if (pre_reg == cb_reg - 16'd1) begin
        pre_next = 16'd0;
        if (strb_reg == sc_reg - 16'd1) begin
          strb_next = 16'd0;
          cs_next   = lampen_reg & ~cs_out;
        end else begin
          strb_next = strb_reg + 16'd1;
        end
      end else begin
        pre_next = pre_reg + 16'd1;
      end

      if (int_last) begin
        count_next = int_count + 16'd1;
        if (!acq_enable) begin
          state_next = IDLE;
          pre_next   = 16'd0;
          strb_next  = 16'd0;
          cs_next    = 1'b0;
        end
      end else if (sub_reg == SUB_LAST) begin
        sub_next = '0;
        ms_next  = ms_reg + 16'd1;
      end else begin
        sub_next = sub_reg + SW'(1);
      end
    end

    // Per-integration shadow copies are taken on the edge that begins k=0.
    if (start_int) begin
      sub_next  = '0;
      ms_next   = 16'd0;
      lint_next = at_least_one(cfg_intclock);
      hi_next   = cfg_sshighdelay;
      lo_next   = cfg_sslowdelay;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg  <= IDLE;
      sub_reg    <= '0;
      ms_reg     <= 16'd0;
      lint_reg   <= 16'd0;
      hi_reg     <= 16'd0;
      lo_reg     <= 16'd0;
      cb_reg     <= 16'd0;
      sc_reg     <= 16'd0;
      pre_reg    <= 16'd0;
      strb_reg   <= 16'd0;
      lampen_reg <= 1'b0;
      int_start  <= 1'b0;
      int_done   <= 1'b0;
      int_active <= 1'b0;
      int_count  <= 16'd0;
      ss_out     <= 1'b0;
      cs_out     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sub_reg    <= sub_next;
      ms_reg     <= ms_next;
      lint_reg   <= lint_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      cb_reg     <= cb_next;
      sc_reg     <= sc_next;
      pre_reg    <= pre_next;
      strb_reg   <= strb_next;
      lampen_reg <= lampen_next;
      int_start  <= start_int;
      int_active <= (state_next == RUN);
      int_done   <= (state_next == RUN) && (sub_next == SUB_LAST) &&
                    (ms_next == lint_next - 16'd1);
      int_count  <= count_next;
      // ms_next never reaches lint_next, so the window's min(Lo, Lint) bound reduces to Lo.
      ss_out     <= (state_next == RUN) && lampen_next && !start_int &&
                    (ms_next >= hi_next) && (ms_next < lo_next);
      cs_out     <= cs_next;
    end
  end

endmodule

// File: tb/tb_strobe_sequencer.sv
// Bench for strobe_sequencer: directed timing scenarios with literal expectations plus a
// randomized run, all checked every cycle against a cycle-position model of the acquisition.
module tb_strobe_sequencer;

  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acq = 1'b0;
  logic [15:0] countbase = 16'd1, strbcount = 16'd1, intclock = 16'd3;
  logic [15:0] lowdelay = 16'd0, highdelay = 16'd0, lampenable = 16'd0;
  logic        int_start, int_done, int_active, ss_out, cs_out;
  logic [15:0] int_count;

  int compared = 0;
  int mismatched = 0;
  bit check_en = 1'b0;

  // Model state: position k within the integration, t cycles since acquisition start.
  bit     m_run = 1'b0;
  longint m_t = 0;
  int     m_k = 0, m_L = 1, m_lint = 1, m_h = 0, m_lo = 0, m_count = 0;
  longint m_cb = 1, m_sc = 1;
  bit     m_lamp = 1'b0;

  always #5 clk = ~clk;

  strobe_sequencer #(.MS_DIV(MS)) dut (
    .sys_clk(clk), .sys_rst(rst), .acq_enable(acq),
    .cfg_countbase(countbase), .cfg_strbcount(strbcount), .cfg_intclock(intclock),
    .cfg_sslowdelay(lowdelay), .cfg_sshighdelay(highdelay), .cfg_lampenable(lampenable),
    .int_start(int_start), .int_done(int_done), .int_active(int_active),
    .int_count(int_count), .ss_out(ss_out), .cs_out(cs_out)
  );

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic new_int();
    m_lint = (intclock == 16'd0) ? 1 : int'(intclock);
    m_L    = m_lint * MS;
    m_h    = int'(highdelay);
    m_lo   = int'(lowdelay);
    m_k    = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      m_run = 1'b0;
      m_count = 0;
    end else if (!m_run) begin
      if (acq) begin
        m_run   = 1'b1;
        m_t     = 0;
        m_count = 0;
        m_cb    = (countbase == 16'd0) ? 1 : longint'(countbase);
        m_sc    = (strbcount == 16'd0) ? 1 : longint'(strbcount);
        m_lamp  = lampenable[0];
        new_int();
      end
    end else if (m_k == m_L - 1) begin
      m_count = (m_count + 1) % 65536;
      if (acq) begin
        new_int();
        m_t++;
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_k++;
      m_t++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      int  win_end;
      bit  exp_ss, exp_cs;
      win_end = ((m_lo < m_lint) ? m_lo : m_lint) * MS;
      exp_ss  = m_run && m_lamp && (m_k != 0) && (m_k >= m_h * MS) && (m_k < win_end);
      exp_cs  = m_run && m_lamp && (((m_t / (m_cb * m_sc)) % 2) == 1);
      check("int_active", int_active, m_run);
      check("int_start", int_start, m_run && (m_k == 0));
      check("int_done", int_done, m_run && (m_k == m_L - 1));
      check("int_count", int_count, m_count);
      check("ss_out", ss_out, exp_ss);
      check("cs_out", cs_out, exp_cs);
    end
  end

  // Ends on a falling edge with reset released; acquisition enable left low.
  task automatic do_reset();
    rst = 1'b1;
    acq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setup(input int ic, input int hi, input int lo, input int cb, input int sc,
                       input int lamp);
    intclock   = 16'(ic);
    highdelay  = 16'(hi);
    lowdelay   = 16'(lo);
    countbase  = 16'(cb);
    strbcount  = 16'(sc);
    lampenable = 16'(lamp);
  endtask

  initial begin
    do_reset();
    check_en = 1'b1;
    check("reset int_active", int_active, 0);
    check("reset int_count", int_count, 0);
    check("reset cs_out", cs_out, 0);

    // Reset mid-run, then restart.
    setup(3, 1, 2, 1, 1, 1);
    acq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 6) begin
        check("rst int_active", int_active, 0);
        check("rst ss_out", ss_out, 0);
        check("rst cs_out", cs_out, 0);
      end
      if (i == 7) check("restart int_start", int_start, 1);
      rst = (i == 5);
    end

    // Back-to-back integrations with a 1..2 ms strobe window.
    do_reset();
    setup(3, 1, 2, 1, 1, 1);
    acq = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0 || i == 12 || i == 24) check("s2 int_start", int_start, 1);
      if (i == 11 || i == 23) check("s2 int_done", int_done, 1);
      if (i == 13) check("s2 int_count", int_count, 1);
      if (i == 25) check("s2 int_count", int_count, 2);
      if (i == 17) check("s2 int_active", int_active, 1);
      if (i == 3 || i == 8) check("s3 ss_out low", ss_out, 0);
      if (i == 4 || i == 7 || i == 16) check("s3 ss_out high", ss_out, 1);
    end

    // Lamp disabled: no strobe, timing unchanged.
    do_reset();
    setup(3, 1, 2, 1, 1, 16'hFFFE);
    acq = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 5) check("lampoff ss_out", ss_out, 0);
      if (i == 11) check("lampoff int_done", int_done, 1);
    end

    // Window boundaries and zero intclock.
    do_reset();
    setup(3, 2, 1, 1, 1, 1);
    acq = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 9) check("lo<=hi ss_out", ss_out, 0);
    end
    do_reset();
    setup(3, 1, 9, 1, 1, 1);
    acq = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 11) check("lo>lint ss_out", ss_out, 1);
      if (i == 12) check("k0 ss_out", ss_out, 0);
    end
    do_reset();
    setup(0, 0, 0, 1, 1, 1);
    acq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) check("ic0 int_done", int_done, 1);
      if (i == 4) check("ic0 int_start", int_start, 1);
    end

    // Continuous strobe period.
    do_reset();
    setup(3, 0, 0, 2, 3, 1);
    acq = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 5 || i == 12) check("cs 2x3 low", cs_out, 0);
      if (i == 6 || i == 11) check("cs 2x3 high", cs_out, 1);
    end
    do_reset();
    setup(3, 0, 0, 0, 0, 1);
    acq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0 || i == 2) check("cs zero low", cs_out, 0);
      if (i == 1) check("cs zero high", cs_out, 1);
    end

    // Mid-integration intclock write and late acq drop.
    do_reset();
    setup(3, 0, 0, 1, 1, 1);
    acq = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i == 11 || i == 31) check("s6 int_done", int_done, 1);
      if (i == 12) check("s6 int_start", int_start, 1);
      if (i == 32) begin
        check("s6 idle int_active", int_active, 0);
        check("s6 idle cs_out", cs_out, 0);
        check("s6 int_count", int_count, 2);
      end
      if (i == 2) intclock = 16'd5;
      if (i == 17) acq = 1'b0;
    end

    // Randomized run.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) acq = ~acq;
      if ($urandom_range(0, 9) == 0) intclock = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) highdelay = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) lowdelay = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) countbase = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) strbcount = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) lampenable = 16'($urandom);
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
